// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// address/count width helpers and the index of the hardwired-zero register.
package reg_file_sb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int ZERO_REG  = 0;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra code point so the count can represent every register.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_file_sb_cell.sv
// One architectural register word: load-enabled flop with asynchronous clear.
module reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending (scoreboard) bit, writeback
// bypass on both read ports and a registered count of pending registers.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = addr_width(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [CW-1:0]    busy_count
);

    // Register 0 and addresses beyond DEPTH are inert for reads, writes and issues.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(ZERO_REG)) && (int'(a) < DEPTH);
    endfunction

    logic             wr_ok;
    logic             iss_ok;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             set_new;
    logic             clr_new;

    assign wr_ok  = wr_en && addr_ok(wr_addr);
    assign iss_ok = issue_en && addr_ok(issue_rd);

    assign regs[ZERO_REG] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (wr_ok && (wr_addr == AW'(i))),
            .d     (wr_data),
            .q     (regs[i])
        );
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (reset && addr_ok(rs1_addr)) begin
            if (wr_ok && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = regs[rs1_addr];
                rs1_busy = busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (reset && addr_ok(rs2_addr)) begin
            if (wr_ok && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = regs[rs2_addr];
                rs2_busy = busy[rs2_addr];
            end
        end
    end

    // Issue is applied after writeback so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    assign set_new = iss_ok && !busy[issue_rd];
    assign clr_new = wr_ok && busy[wr_addr] && !(iss_ok && (issue_rd == wr_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + CW'(set_new) - CW'(clr_new);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus a randomized phase checked
// against a behavioural register/pending model through an expected queue.
module tb_reg_file_sb;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          issue_en;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [CW-1:0] busy_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    logic [W-1:0] m_regs [D];
    bit           m_busy [D];

    reg_file_sb dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [W-1:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
        if (!reset || a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!reset || a == 0) return 1'b0;
        return m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_rd = '0;
    endtask

    // Model absorbs the inputs present at the coming edge, then we step past it.
    task automatic tick();
        if (reset) begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_model();
        push("rnd_rs1_data", exp_data(rs1_addr));
        push("rnd_rs2_data", exp_data(rs2_addr));
        push("rnd_rs1_busy", 32'(exp_busy(rs1_addr)));
        push("rnd_rs2_busy", 32'(exp_busy(rs2_addr)));
        push("rnd_count", 32'(m_count()));
    endtask

    task automatic pop_all();
        pop_check(rs1_data);
        pop_check(rs2_data);
        pop_check(32'(rs1_busy));
        pop_check(32'(rs2_busy));
        pop_check(32'(busy_count));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_clear();
        rs1_addr = 5;
        rs2_addr = 0;
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1111_1111;
        issue_en = 1'b1; issue_rd = 5;
        repeat (2) tick();
        push("rst_rs1_data", 0); pop_check(rs1_data);
        push("rst_rs1_busy", 0); pop_check(32'(rs1_busy));
        push("rst_count", 0);    pop_check(32'(busy_count));

        idle();
        reset = 1'b1;
        #1;
        push("rel_x5", 0);    pop_check(rs1_data);
        push("rel_count", 0); pop_check(32'(busy_count));

        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        tick();
        idle(); rs1_addr = 5; #1;
        push("x5_data", 32'hDEAD_BEEF); pop_check(rs1_data);
        push("x5_busy", 0);             pop_check(32'(rs1_busy));

        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234_5678; rs1_addr = 0; #1;
        push("x0_bypass", 0); pop_check(rs1_data);
        tick();
        idle(); #1;
        push("x0_data", 0);  pop_check(rs1_data);
        push("x0_count", 0); pop_check(32'(busy_count));

        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5_A5A5; rs2_addr = 7; #1;
        push("byp7_data", 32'hA5A5_A5A5); pop_check(rs2_data);
        push("byp7_busy", 0);             pop_check(32'(rs2_busy));
        tick();
        idle();

        issue_en = 1'b1; issue_rd = 3;
        tick();
        idle(); rs1_addr = 3; #1;
        push("x3_busy", 1);  pop_check(32'(rs1_busy));
        push("x3_count", 1); pop_check(32'(busy_count));
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55; #1;
        push("x3_byp_data", 32'h55); pop_check(rs1_data);
        push("x3_byp_busy", 0);      pop_check(32'(rs1_busy));
        tick();
        idle(); #1;
        push("x3_wb_busy", 0);    pop_check(32'(rs1_busy));
        push("x3_wb_count", 0);   pop_check(32'(busy_count));
        push("x3_wb_data", 32'h55); pop_check(rs1_data);

        issue_en = 1'b1; issue_rd = 3;
        repeat (2) tick();
        idle(); #1;
        push("reissue_busy", 1);  pop_check(32'(rs1_busy));
        push("reissue_count", 1); pop_check(32'(busy_count));
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h56;
        tick();
        idle();

        issue_en = 1'b1; issue_rd = 4;
        tick();
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h99;
        tick();
        idle(); rs1_addr = 4; #1;
        push("x4_data", 32'h99); pop_check(rs1_data);
        push("x4_busy", 1);      pop_check(32'(rs1_busy));
        push("x4_count", 1);     pop_check(32'(busy_count));

        wr_en = 1'b1; wr_addr = 8; wr_data = 32'h0BAD;
        tick();
        idle(); rs2_addr = 8; #1;
        push("x8_data", 32'h0BAD); pop_check(rs2_data);
        push("x8_busy", 0);        pop_check(32'(rs2_busy));
        push("x8_count", 1);       pop_check(32'(busy_count));

        issue_en = 1'b1;
        issue_rd = 2; tick();
        issue_rd = 6; tick();
        issue_rd = 9; tick();
        idle(); #1;
        push("multi_count", 4); pop_check(32'(busy_count));

        wr_en = 1'b1; wr_addr = 2; wr_data = 32'hFFFF;
        issue_en = 1'b1; issue_rd = 10;
        rs1_addr = 2; rs2_addr = 4;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        push("mrst_rs1_data", 0); pop_check(rs1_data);
        push("mrst_rs2_data", 0); pop_check(rs2_data);
        push("mrst_rs1_busy", 0); pop_check(32'(rs1_busy));
        push("mrst_rs2_busy", 0); pop_check(32'(rs2_busy));
        push("mrst_count", 0);    pop_check(32'(busy_count));
        idle();
        #1;
        reset = 1'b1;
        tick();
        push("post_x2", 0);    pop_check(rs1_data);
        push("post_x4", 0);    pop_check(rs2_data);
        push("post_count", 0); pop_check(32'(busy_count));

        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, D - 1)) : AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            issue_en = ($urandom_range(0, 1) != 0);
            issue_rd = AW'($urandom_range(0, 7));
            rs1_addr = AW'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 1) != 0) ? wr_addr : AW'($urandom_range(0, D - 1));
            push_model();
            #1;
            pop_all();
            tick();
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
